// File: rtl/cart_rom_fetch_pkg.sv
// Shared slots package for the cartridge ROM fetch path: FSM states and the
// value returned for unmapped or failed reads.
package cart_rom_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_ACK = 2'd2,
      DONE     = 2'd3
   } fetch_state_e;

   localparam logic [7:0] UNMAPPED_DATA = 8'hFF;
   localparam int         ADDR_W        = 25;

endpackage

// File: rtl/cart_rom_fetch.sv
// Cartridge ROM read path: single-entry byte cache in front of a
// request/acknowledge memory port, holding the CPU with wait_n while a miss is fetched.
module cart_rom_fetch
   import cart_rom_fetch_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        rd,
   input  logic [24:0] mem_addr,
   input  logic        mem_unmaped,
   input  logic        rom_reload,
   output logic [7:0]  d_to_cpu,
   output logic        wait_n,
   output logic [24:0] ram_addr,
   output logic        ram_req,
   input  logic        ram_ack,
   input  logic [7:0]  ram_din
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_req_q, ram_req_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] tag_q, tag_d;
   logic [7:0]        data_q, data_d;
   logic              served_q, served_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              reload_seen_q, reload_seen_d;
   logic              orphan_q, orphan_d;

   logic access;
   logic hit;
   logic idle_view;

   assign access = cs & rd;
   assign hit    = valid_q && (tag_q == mem_addr);

   // A fetch whose access was dropped still finishes, but its DONE cycle must
   // not answer a new access that happens to start then; that access is
   // judged against the freshly filled cache exactly as IDLE would.
   assign idle_view = (state_q == IDLE) || ((state_q == DONE) && orphan_q);

   always_comb begin
      state_d       = state_q;
      ram_addr_d    = ram_addr_q;
      ram_req_d     = 1'b0;
      valid_d       = valid_q;
      tag_d         = tag_q;
      data_d        = data_q;
      served_d      = access ? served_q : 1'b0;
      cnt_d         = cnt_q;
      reload_seen_d = reload_seen_q | rom_reload;
      orphan_d      = orphan_q;

      unique case (state_q)
         IDLE: begin
            if (access && !mem_unmaped && !hit && !served_q) begin
               state_d       = REQ;
               ram_addr_d    = mem_addr;
               ram_req_d     = 1'b1;
               reload_seen_d = rom_reload;
               orphan_d      = 1'b0;
            end else if (access && (mem_unmaped || hit)) begin
               served_d = 1'b1;
            end
         end
         REQ: begin
            state_d  = WAIT_ACK;
            cnt_d    = '0;
            orphan_d = orphan_q | ~access;
         end
         WAIT_ACK: begin
            orphan_d = orphan_q | ~access;
            if (ram_ack) begin
               state_d = DONE;
               data_d  = ram_din;
               tag_d   = ram_addr_q;
               valid_d = ~(rom_reload | reload_seen_q);
            end else if (cnt_q >= CNT_LAST) begin
               state_d = DONE;
               data_d  = UNMAPPED_DATA;
               valid_d = 1'b0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (!access || orphan_q) begin
               state_d = IDLE;
            end else begin
               served_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A reload always wins, including over a fill in this same cycle.
      if (rom_reload) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         ram_addr_q    <= '0;
         ram_req_q     <= 1'b0;
         valid_q       <= 1'b0;
         tag_q         <= '0;
         data_q        <= UNMAPPED_DATA;
         served_q      <= 1'b0;
         cnt_q         <= '0;
         reload_seen_q <= 1'b0;
         orphan_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ram_addr_q    <= ram_addr_d;
         ram_req_q     <= ram_req_d;
         valid_q       <= valid_d;
         tag_q         <= tag_d;
         data_q        <= data_d;
         served_q      <= served_d;
         cnt_q         <= cnt_d;
         reload_seen_q <= reload_seen_d;
         orphan_q      <= orphan_d;
      end
   end

   // wait_n drops in the very cycle a miss is seen so stale data is never sampled.
   always_comb begin
      wait_n   = 1'b1;
      d_to_cpu = UNMAPPED_DATA;
      if (!reset) begin
         if (idle_view) begin
            if (access && !mem_unmaped) begin
               if (hit || served_q) begin
                  d_to_cpu = data_q;
               end else begin
                  wait_n = 1'b0;
               end
            end
         end else if ((state_q == REQ) || (state_q == WAIT_ACK)) begin
            wait_n = 1'b0;
         end else if (access && !mem_unmaped) begin
            d_to_cpu = data_q;
         end
      end
   end

   assign ram_addr = ram_addr_q;
   assign ram_req  = ram_req_q;

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Bench for cart_rom_fetch: table of CPU reads with a scoreboard of expected
// read data, plus hand sequences for abandoned fetches and mid-fetch reset.
module tb_cart_rom_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs, rd, mem_unmaped, rom_reload, ram_ack;
   logic [24:0] mem_addr;
   logic [7:0]  ram_din;
   logic [7:0]  d_to_cpu;
   logic        wait_n;
   logic [24:0] ram_addr;
   logic        ram_req;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   cart_rom_fetch #(.TIMEOUT(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .cs         (cs),
      .rd         (rd),
      .mem_addr   (mem_addr),
      .mem_unmaped(mem_unmaped),
      .rom_reload (rom_reload),
      .d_to_cpu   (d_to_cpu),
      .wait_n     (wait_n),
      .ram_addr   (ram_addr),
      .ram_req    (ram_req),
      .ram_ack    (ram_ack),
      .ram_din    (ram_din)
   );

   // reload_mode: 0 none, 1 with the ack, 2 in the first WAIT_ACK cycle.
   // ack_dly: cycles from the ram_req cycle to the ack cycle, -1 for no ack.
   typedef struct {
      logic [24:0] addr;
      logic        unm;
      int          ack_dly;
      logic [7:0]  din;
      int          reload_mode;
      logic [7:0]  exp_data;
      int          exp_low;
      int          exp_reqs;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_read(input vec_t v, input int idx);
      int cyc = 0;
      int low = 0;
      int reqs = 0;
      int req_cyc = -100;
      bit done = 0;
      logic [7:0] exp;
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; mem_addr = v.addr; mem_unmaped = v.unm;
      exp_q.push_back(v.exp_data);
      #1;
      while (!done && cyc < 40) begin
         ram_ack = 1'b0; rom_reload = 1'b0;
         if (ram_req === 1'b1) begin
            reqs++;
            req_cyc = cyc;
            check($sformatf("v%0d ram_addr", idx), 32'(ram_addr), 32'(v.addr));
         end
         if (wait_n === 1'b1) begin
            done = 1;
            exp = exp_q.pop_front();
            check($sformatf("v%0d d_to_cpu", idx), 32'(d_to_cpu), 32'(exp));
         end else begin
            low++;
         end
         if (!done && v.ack_dly > 0 && cyc == req_cyc + v.ack_dly) begin
            ram_ack = 1'b1; ram_din = v.din;
            if (v.reload_mode == 1) rom_reload = 1'b1;
         end
         if (!done && v.reload_mode == 2 && cyc == req_cyc + 1) rom_reload = 1'b1;
         if (!done) begin
            @(negedge clk); #1;
            cyc++;
         end
      end
      if (!done) begin
         check($sformatf("v%0d completion", idx), 32'(0), 32'(1));
         if (exp_q.size() > 0) exp = exp_q.pop_front();
      end
      check($sformatf("v%0d wait_low_cycles", idx), 32'(low), 32'(v.exp_low));
      // A late ack landing in DONE must be ignored.
      if (v.ack_dly < 0) begin
         ram_ack = 1'b1; ram_din = 8'hEE;
      end
      cs = 1'b0; rd = 1'b0;
      @(negedge clk); #1;
      ram_ack = 1'b0; rom_reload = 1'b0;
      if (ram_req === 1'b1) reqs++;
      check($sformatf("v%0d ram_req_count", idx), 32'(reqs), 32'(v.exp_reqs));
      check($sformatf("v%0d idle d_to_cpu", idx), 32'(d_to_cpu), 32'(8'hFF));
      check($sformatf("v%0d idle wait_n", idx), 32'(wait_n), 32'(1));
   endtask

   task automatic wait_req(output bit seen);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk); #1;
         if (ram_req === 1'b1) seen = 1;
      end
      if (!seen) check("ram_req seen", 32'(0), 32'(1));
   endtask

   vec_t vecs[13];
   vec_t post[2];

   initial begin
      bit seen;
      vecs[0]  = '{25'h004123, 1'b0,  3, 8'h5A, 0, 8'h5A,  5, 1};
      vecs[1]  = '{25'h004123, 1'b0,  3, 8'h00, 0, 8'h5A,  0, 0};
      vecs[2]  = '{25'h004123, 1'b1,  3, 8'h00, 0, 8'hFF,  0, 0};
      vecs[3]  = '{25'h1ABCDE, 1'b0,  1, 8'hC3, 0, 8'hC3,  3, 1};
      vecs[4]  = '{25'h1ABCDE, 1'b0,  1, 8'h00, 0, 8'hC3,  0, 0};
      vecs[5]  = '{25'h004123, 1'b0,  8, 8'h11, 0, 8'h11, 10, 1};
      vecs[6]  = '{25'h0000FF, 1'b0, -1, 8'h00, 0, 8'hFF, 10, 1};
      vecs[7]  = '{25'h0000FF, 1'b0,  2, 8'h22, 0, 8'h22,  4, 1};
      vecs[8]  = '{25'h000777, 1'b0,  3, 8'h3C, 1, 8'h3C,  5, 1};
      vecs[9]  = '{25'h000777, 1'b0,  2, 8'h3D, 0, 8'h3D,  4, 1};
      vecs[10] = '{25'h000777, 1'b0,  2, 8'h00, 0, 8'h3D,  0, 0};
      vecs[11] = '{25'h000888, 1'b0,  3, 8'h44, 2, 8'h44,  5, 1};
      vecs[12] = '{25'h000888, 1'b0,  1, 8'h45, 0, 8'h45,  3, 1};

      reset = 1'b1; cs = 1'b0; rd = 1'b0; mem_unmaped = 1'b0; rom_reload = 1'b0;
      ram_ack = 1'b0; mem_addr = '0; ram_din = '0;
      #1;
      check("reset wait_n", 32'(wait_n), 32'(1));
      check("reset d_to_cpu", 32'(d_to_cpu), 32'(8'hFF));
      check("reset ram_req", 32'(ram_req), 32'(0));
      check("reset ram_addr", 32'(ram_addr), 32'(0));
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) do_read(vecs[i], i);

      // Access dropped right after ram_req: fetch still completes and fills.
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; mem_addr = 25'h000ABC; mem_unmaped = 1'b0;
      wait_req(seen);
      cs = 1'b0; rd = 1'b0;
      @(negedge clk); #1;
      check("abort wait_n in WAIT_ACK", 32'(wait_n), 32'(0));
      @(negedge clk); #1;
      ram_ack = 1'b1; ram_din = 8'h5F;
      @(negedge clk); #1;
      ram_ack = 1'b0;
      @(negedge clk); #1;
      check("abort idle wait_n", 32'(wait_n), 32'(1));
      do_read('{25'h000ABC, 1'b0, 1, 8'h00, 0, 8'h5F, 0, 0}, 100);

      // Reset in WAIT_ACK abandons the fetch; the late ack must not fill.
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; mem_addr = 25'h0BEEF0;
      wait_req(seen);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset wait_n", 32'(wait_n), 32'(1));
      check("midreset d_to_cpu", 32'(d_to_cpu), 32'(8'hFF));
      cs = 1'b0; rd = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #1;
      ram_ack = 1'b1; ram_din = 8'h99;
      @(negedge clk); #1;
      ram_ack = 1'b0;
      post[0] = '{25'h000ABC, 1'b0, 1, 8'h61, 0, 8'h61, 3, 1};
      post[1] = '{25'h0BEEF0, 1'b0, 2, 8'h44, 0, 8'h44, 4, 1};
      for (int i = 0; i < 2; i++) do_read(post[i], 200 + i);

      check("scoreboard empty", 32'(exp_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
